// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one dpram64 port between two requesters, with a
// bounded lock that lets one master keep the port for up to MAX_BURST accesses.
module mem_port_arbiter #(
    parameter int MAX_BURST = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_m0_req,
    input  logic        i_m0_lock,
    input  logic        i_m0_we,
    input  logic [31:0] i_m0_addr,
    input  logic [7:0]  i_m0_be,
    input  logic [63:0] i_m0_wdata,
    output logic        o_m0_gnt,
    output logic        o_m0_rvalid,
    output logic [63:0] o_m0_rdata,
    input  logic        i_m1_req,
    input  logic        i_m1_lock,
    input  logic        i_m1_we,
    input  logic [31:0] i_m1_addr,
    input  logic [7:0]  i_m1_be,
    input  logic [63:0] i_m1_wdata,
    output logic        o_m1_gnt,
    output logic        o_m1_rvalid,
    output logic [63:0] o_m1_rdata,
    output logic [7:0]  o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [63:0] o_mem_wdata,
    input  logic [63:0] i_mem_rdata
);

    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} owner_t;

    owner_t        owner, owner_next;
    logic          last, last_next;
    logic [CW-1:0] cnt, cnt_next, cnt_base;
    logic          rv0, rv1;
    logic          held0, held1;
    logic          gnt0, gnt1;
    logic          gnt_lock;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner <= IDLE;
            last  <= 1'b1;
            cnt   <= '0;
            rv0   <= 1'b0;
            rv1   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            owner <= owner_next;
            last  <= last_next;
            cnt   <= cnt_next;
            rv0   <= gnt0 & ~i_m0_we;
            rv1   <= gnt1 & ~i_m1_we;
        end
    end

    // Next-state: lock counting restarts whenever the grant is not a continuation.
    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned (no latches).
        owner_next = owner;
        last_next  = last;
        cnt_next   = cnt;
        cnt_base   = (held0 || held1) ? cnt : '0;
        gnt_lock   = gnt0 ? i_m0_lock : i_m1_lock;
        if (gnt0 || gnt1) begin
            last_next = gnt1;
            if (gnt_lock && (int'(cnt_base) + 1 < MAX_BURST)) begin
                owner_next = gnt0 ? OWN0 : OWN1;
                cnt_next   = cnt_base + CW'(1);
            end else begin
                owner_next = IDLE;
                cnt_next   = '0;
            end
        end else if (owner != IDLE) begin
            owner_next = IDLE;
            cnt_next   = '0;
        end
    end

    // Outputs: a held owner blocks the other master; otherwise plain round-robin.
    always_comb begin
        held0 = (owner == OWN0) && i_m0_req;
        held1 = (owner == OWN1) && i_m1_req;
        gnt0  = 1'b0;
        gnt1  = 1'b0;
        if (rst) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end else if (held0) begin
            gnt0 = 1'b1;
        end else if (held1) begin
            gnt1 = 1'b1;
        end else if (i_m0_req && i_m1_req) begin
            gnt0 = last;
            gnt1 = ~last;
        end else begin
            gnt0 = i_m0_req;
            gnt1 = i_m1_req;
        end

        o_mem_we    = '0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        if (gnt0) begin
            o_mem_we    = {8{i_m0_we}} & i_m0_be;
            o_mem_addr  = i_m0_addr;
            o_mem_wdata = i_m0_wdata;
        end else if (gnt1) begin
            o_mem_we    = {8{i_m1_we}} & i_m1_be;
            o_mem_addr  = i_m1_addr;
            o_mem_wdata = i_m1_wdata;
        end
    end

    assign o_m0_gnt    = gnt0;
    assign o_m1_gnt    = gnt1;
    assign o_m0_rvalid = rv0;
    assign o_m1_rvalid = rv1;
    assign o_m0_rdata  = i_mem_rdata;
    assign o_m1_rdata  = i_mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with MAX_BURST=4 and a byte-enabled
// memory model standing in for dpram64 (one-cycle read latency).
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_lock, m0_we;
    logic [31:0] m0_addr;
    logic [7:0]  m0_be;
    logic [63:0] m0_wdata;
    logic        m0_gnt, m0_rvalid;
    logic [63:0] m0_rdata;
    logic        m1_req, m1_lock, m1_we;
    logic [31:0] m1_addr;
    logic [7:0]  m1_be;
    logic [63:0] m1_wdata;
    logic        m1_gnt, m1_rvalid;
    logic [63:0] m1_rdata;
    logic [7:0]  mem_we;
    logic [31:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;

    logic        pre_en;
    logic [7:0]  pre_idx;
    logic [63:0] pre_data;
    logic [63:0] mem [0:255];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MAX_BURST(4)) dut (
        .clk(clk), .rst(rst),
        .i_m0_req(m0_req), .i_m0_lock(m0_lock), .i_m0_we(m0_we),
        .i_m0_addr(m0_addr), .i_m0_be(m0_be), .i_m0_wdata(m0_wdata),
        .o_m0_gnt(m0_gnt), .o_m0_rvalid(m0_rvalid), .o_m0_rdata(m0_rdata),
        .i_m1_req(m1_req), .i_m1_lock(m1_lock), .i_m1_we(m1_we),
        .i_m1_addr(m1_addr), .i_m1_be(m1_be), .i_m1_wdata(m1_wdata),
        .o_m1_gnt(m1_gnt), .o_m1_rvalid(m1_rvalid), .o_m1_rdata(m1_rdata),
        .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
        .i_mem_rdata(mem_rdata)
    );

    // Memory model: byte-enabled write, registered read of the pre-write word.
    always @(posedge clk) begin
        if (pre_en) begin
            mem[pre_idx] <= pre_data;
        end else begin
            for (int b = 0; b < 8; b++)
                if (mem_we[b]) mem[mem_addr[10:3]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
        mem_rdata <= mem[mem_addr[10:3]];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic drive0(input logic req, input logic lock, input logic we,
                          input logic [31:0] addr, input logic [7:0] be, input logic [63:0] wdata);
        m0_req = req; m0_lock = lock; m0_we = we; m0_addr = addr; m0_be = be; m0_wdata = wdata;
    endtask

    task automatic drive1(input logic req, input logic lock, input logic we,
                          input logic [31:0] addr, input logic [7:0] be, input logic [63:0] wdata);
        m1_req = req; m1_lock = lock; m1_we = we; m1_addr = addr; m1_be = be; m1_wdata = wdata;
    endtask

    task automatic idle_both();
        drive0(1'b0, 1'b0, 1'b0, 32'h0, 8'h00, 64'h0);
        drive1(1'b0, 1'b0, 1'b0, 32'h0, 8'h00, 64'h0);
    endtask

    task automatic check_gnt(input string tag, input logic e0, input logic e1);
        check({tag, "_gnt0"}, m0_gnt, e0);
        check({tag, "_gnt1"}, m1_gnt, e1);
    endtask

    initial begin
        // Lock pattern for MAX_BURST=4 with both masters requesting: m0 x4, m1, m0 x4
        logic [8:0] lock_pat;
        lock_pat = 9'b1_1110_1111;

        rst = 1'b1;
        pre_en = 1'b0; pre_idx = '0; pre_data = '0;
        idle_both();

        // Reset: preload memory, requests are ignored while rst is high
        @(negedge clk);
        pre_en = 1'b1; pre_idx = 8'h02; pre_data = 64'h1122334455667788;
        @(negedge clk);
        pre_idx = 8'h04; pre_data = 64'h0;
        @(negedge clk);
        pre_en = 1'b0;
        drive0(1'b1, 1'b1, 1'b1, 32'h10, 8'hFF, 64'hDEAD);
        drive1(1'b1, 1'b0, 1'b1, 32'h20, 8'hFF, 64'hBEEF);
        #1;
        check_gnt("reset", 1'b0, 1'b0);
        check("reset_rv0", m0_rvalid, 1'b0);
        check("reset_rv1", m1_rvalid, 1'b0);
        check("reset_we", mem_we, 8'h00);
        check("reset_addr", mem_addr, 32'h0);
        check("reset_wdata", mem_wdata, 64'h0);
        @(negedge clk);
        idle_both();
        rst = 1'b0;

        // Single read by m0
        @(negedge clk);
        drive0(1'b1, 1'b0, 1'b0, 32'h10, 8'h00, 64'h0);
        #1;
        check_gnt("rd0", 1'b1, 1'b0);
        check("rd0_addr", mem_addr, 32'h10);
        check("rd0_we", mem_we, 8'h00);
        @(negedge clk);
        idle_both();
        #1;
        check("rd0_rv0", m0_rvalid, 1'b1);
        check("rd0_rdata", m0_rdata, 64'h1122334455667788);
        check("rd0_rv1", m1_rvalid, 1'b0);
        @(negedge clk);
        #1;
        check("rd0_rv0_once", m0_rvalid, 1'b0);

        // Single read by m1 (also leaves last=1)
        @(negedge clk);
        drive1(1'b1, 1'b0, 1'b0, 32'h10, 8'h00, 64'h0);
        #1;
        check_gnt("rd1", 1'b0, 1'b1);
        @(negedge clk);
        idle_both();
        #1;
        check("rd1_rv1", m1_rvalid, 1'b1);
        check("rd1_rv0", m0_rvalid, 1'b0);
        check("rd1_rdata", m1_rdata, 64'h1122334455667788);

        // Round-robin tie, unlocked reads: m0, m1, m0, m1
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i < 4) begin
                drive0(1'b1, 1'b0, 1'b0, 32'h10, 8'hFF, 64'h0);
                drive1(1'b1, 1'b0, 1'b0, 32'h10, 8'hFF, 64'h0);
            end else begin
                idle_both();
            end
            #1;
            if (i < 4) begin
                check_gnt($sformatf("rr%0d", i), (i % 2) == 0, (i % 2) == 1);
                check($sformatf("rr%0d_we", i), mem_we, 8'h00);
            end
            if (i > 0) begin
                check($sformatf("rr%0d_rv0", i), m0_rvalid, ((i - 1) % 2) == 0);
                check($sformatf("rr%0d_rv1", i), m1_rvalid, ((i - 1) % 2) == 1);
            end
        end

        // Write with be=0 by m0: granted, no bytes change
        @(negedge clk);
        drive0(1'b1, 1'b0, 1'b1, 32'h20, 8'h00, 64'h1234567812345678);
        #1;
        check_gnt("be0", 1'b1, 1'b0);
        check("be0_we", mem_we, 8'h00);

        // Byte-enabled write by m1
        @(negedge clk);
        idle_both();
        drive1(1'b1, 1'b0, 1'b1, 32'h20, 8'h0F, 64'hFFFFFFFFFFFFFFFF);
        #1;
        check_gnt("bew", 1'b0, 1'b1);
        check("bew_we", mem_we, 8'h0F);
        check("bew_addr", mem_addr, 32'h20);
        check("bew_wdata", mem_wdata, 64'hFFFFFFFFFFFFFFFF);
        check("be0_rv0", m0_rvalid, 1'b0);
        @(negedge clk);
        drive1(1'b1, 1'b0, 1'b0, 32'h20, 8'h00, 64'h0);
        #1;
        check("bew_rv1", m1_rvalid, 1'b0);
        check_gnt("bew_rd", 1'b0, 1'b1);
        @(negedge clk);
        idle_both();
        #1;
        check("bew_rd_rv1", m1_rvalid, 1'b1);
        check("bew_rd_data", m1_rdata, 64'h00000000FFFFFFFF);

        // Lock and limit: m0 locked, m1 always requesting
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            drive0(1'b1, 1'b1, 1'b0, 32'h10, 8'h00, 64'h0);
            drive1(1'b1, 1'b0, 1'b0, 32'h10, 8'h00, 64'h0);
            #1;
            check_gnt($sformatf("lock%0d", i), lock_pat[i], ~lock_pat[i]);
            check($sformatf("lock%0d_mutex", i), m0_gnt & m1_gnt, 1'b0);
        end

        // Lock release by idle: last=0 now, so a held owner must beat the tie
        @(negedge clk);
        idle_both();
        drive0(1'b1, 1'b1, 1'b0, 32'h10, 8'h00, 64'h0);
        #1;
        check_gnt("rel_a", 1'b1, 1'b0);
        @(negedge clk);
        drive1(1'b1, 1'b0, 1'b0, 32'h18, 8'h00, 64'h0);
        #1;
        check_gnt("rel_hold", 1'b1, 1'b0);
        @(negedge clk);
        drive0(1'b0, 1'b1, 1'b0, 32'h10, 8'h00, 64'h0);
        #1;
        check_gnt("rel_drop", 1'b0, 1'b1);
        check("rel_addr", mem_addr, 32'h18);

        // Asynchronous reset during a locked m0 read
        @(negedge clk);
        idle_both();
        drive0(1'b1, 1'b1, 1'b0, 32'h10, 8'h00, 64'h0);
        #1;
        check_gnt("ar_pre", 1'b1, 1'b0);
        @(negedge clk);
        #1;
        check_gnt("ar_pre2", 1'b1, 1'b0);
        check("ar_pre_rv0", m0_rvalid, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        check_gnt("ar_in", 1'b0, 1'b0);
        check("ar_rv0", m0_rvalid, 1'b0);
        check("ar_rv1", m1_rvalid, 1'b0);
        check("ar_we", mem_we, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        drive0(1'b1, 1'b0, 1'b0, 32'h10, 8'h00, 64'h0);
        drive1(1'b1, 1'b0, 1'b0, 32'h18, 8'h00, 64'h0);
        #1;
        check_gnt("ar_tie", 1'b1, 1'b0);
        check("ar_tie_rv0", m0_rvalid, 1'b0);
        @(negedge clk);
        idle_both();
        #1;
        check("ar_post_rv0", m0_rvalid, 1'b1);
        check("ar_post_rv1", m1_rvalid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
